// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the parallel-in serial-out serializer family.
// Holds the FSM state encodings and the counter-width helper used to size
// the bit and clock-division counters.
package piso_serializer_pkg;

  // Two-state FSM encoding, kept as plain 1-bit constants so older tools
  // and netlists see a stable encoding.
  localparam logic S_IDLE  = 1'b0;
  localparam logic S_SHIFT = 1'b1;

  // Bits needed to hold a count in 0..range-1, never less than one bit.
  // $clog2 returns 0 for range 1, which would give a zero-width vector.
  function automatic int cnt_width(input int range);
    if (range <= 2) begin
      return 1;
    end
    return $clog2(range);
  endfunction

endpackage : piso_serializer_pkg

// File: rtl/piso_serializer_bit_period_counter.sv
// Purpose    : holds each serial bit for CLK_DIV clocks; emits a wrap tick on
//              the final clock of every bit period.
// Latency    : tick is combinational from the registered count (same cycle).
// Backpressure: none; the owner gates progress with en and restarts with clr.
//
// Ports:
//   clk   system clock, rising edge
//   rstn  synchronous reset, active-low; clears the count
//   clr   restart the period (count to 0 at the next edge); wins over en
//   en    advance the count this cycle
//   tick  high when en is set and the count is on its last value
module bit_period_counter
  import piso_serializer_pkg::*;
#(
  parameter int CLK_DIV = 1
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int DW = cnt_width(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt;
  logic          at_last;

  // With CLK_DIV=1 DIV_LAST is 0, so the count never leaves 0 and the tick
  // fires every enabled cycle.
  assign at_last = (div_cnt == DIV_LAST);
  assign tick    = en & at_last;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      div_cnt <= '0;
    end else if (clr) begin
      div_cnt <= '0;
    end else if (en) begin
      if (at_last) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

endmodule : bit_period_counter

// File: rtl/piso_serializer.sv
// Purpose    : parallel-in serial-out shifter with frame qualifier and an
//              end-of-word pulse.
// Latency    : first bit on sout 1 cycle after the handshake; a word holds
//              the line for WIDTH*CLK_DIV cycles; sdone the cycle after.
// Backpressure: din_ready is high only in IDLE or in the last cycle of a
//              word, so a held din_valid streams words back-to-back.
//
// Ports:
//   clk        system clock, rising edge
//   rstn       synchronous reset, active-low (also masks din_ready)
//   din        parallel word, sampled only at a handshake
//   din_valid  upstream offers a word
//   din_ready  word can be accepted this cycle
//   sout       serial data, 0 when no frame is active
//   sframe     high while sout carries a valid bit
//   sdone      one-cycle pulse after the last bit of each word
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int CLK_DIV   = 1,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sframe,
  output logic             sdone
);

  localparam int BW = cnt_width(WIDTH);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  logic             state;
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0]    bit_cnt;
  logic             sdone_q;

  logic             shifting;
  logic             bit_tick;
  logic             last_bit;
  logic             last_cyc;
  logic             accept;
  logic             out_bit;

  assign shifting = (state == S_SHIFT);
  assign last_bit = (bit_cnt == BIT_LAST);

  // Bit period timing lives in the reusable counter; a new word restarts
  // the period so its first bit gets the full CLK_DIV cycles.
  bit_period_counter #(
    .CLK_DIV (CLK_DIV)
  ) u_bit_period (
    .clk  (clk),
    .rstn (rstn),
    .clr  (accept),
    .en   (shifting),
    .tick (bit_tick)
  );

  // Final cycle of the word: the next word may be taken here so the line
  // never idles between chained words.
  assign last_cyc = shifting & last_bit & bit_tick;

  // Reset masks ready combinationally so a word offered while rstn is low
  // is never considered accepted.
  assign din_ready = rstn & (~shifting | last_cyc);
  assign accept    = din_valid & din_ready;

  // Output tap follows the shift direction; the register fills with zeros.
  assign out_bit = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];

  assign sout   = shifting & out_bit;
  assign sframe = shifting;
  assign sdone  = sdone_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= S_IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      sdone_q <= 1'b0;
    end else begin
      // Pulse once per completed word, chained or not.
      sdone_q <= last_cyc;

      if (accept) begin
        // Covers both a fresh start from IDLE and a chained load in the
        // last cycle of the previous word.
        shreg   <= din;
        bit_cnt <= '0;
        state   <= S_SHIFT;
      end else if (shifting && bit_tick) begin
        if (MSB_FIRST) begin
          shreg <= {shreg[WIDTH-2:0], 1'b0};
        end else begin
          shreg <= {1'b0, shreg[WIDTH-1:1]};
        end

        if (last_bit) begin
          bit_cnt <= '0;
          state   <= S_IDLE;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end

endmodule : piso_serializer
